sigma_delta_adc_mc: RTL and testbench

Multi-channel sigma-delta ADC front end. It closes the first-order modulator loop for `CHAN` independent external RC integrators and decimates each 1-bit stream through a `STGS`-stage CIC filter. Each channel's comb section is evaluated in turn, one channel per clock cycle, after every decimation strobe. Results are saturated, scaled to `OUT_W` bits, and delivered through a small FIFO with a valid/ready handshake; this replaces the single-channel `sigma_delta_adc` in new designs.

---
 rtl/sigma_delta_pkg.sv | 21 ++
 rtl/sd_sample_fifo.sv | 44 ++++
 rtl/sigma_delta_adc_mc.sv | 129 ++++++++++++
 tb/tb_sigma_delta_adc_mc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// sigma_delta_pkg: shared types, width helpers and parameter checks for sigma_delta_adc_mc.
package sigma_delta_pkg;
    typedef enum logic {IDLE, COMB} seq_t;

    function automatic int log_fs(int bosr, int stgs);
        return stgs * $clog2(bosr);
    endfunction

    function automatic int def_wdth(int bosr, int stgs);
        return 2 + log_fs(bosr, stgs);
    endfunction

    function automatic bit is_pow2(int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction

    function automatic bit params_ok(int chan, int bosr, int stgs, int wdth, int fifo_d);
        return chan >= 1 && is_pow2(bosr) && bosr >= chan + 2 && stgs >= 1 && stgs <= 4
            && wdth >= log_fs(bosr, stgs) + 1 && is_pow2(fifo_d);
    endfunction
endpackage

// File: rtl/sd_sample_fifo.sv
// sd_sample_fifo: registered sample FIFO without fall-through; a pop frees room for a same-cycle push.
module sd_sample_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int CNW = AW + 1;

    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [CNW-1:0] cnt;
    logic           wr, rd;

    assign full  = cnt == CNW'(DEPTH);
    assign empty = cnt == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign head  = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= din;
                wp      <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            end
            if (rd) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt + CNW'(wr) - CNW'(rd);
        end
    end
endmodule

// File: rtl/sigma_delta_adc_mc.sv
// sigma_delta_adc_mc: multi-channel first-order sigma-delta loop with per-channel CIC integrators
// and a single comb datapath time-shared across channels after each decimation strobe.
module sigma_delta_adc_mc
    import sigma_delta_pkg::*;
#(
    parameter int CHAN   = 2,
    parameter int BOSR   = 256,
    parameter int STGS   = 2,
    parameter int WDTH   = def_wdth(BOSR, STGS),
    parameter int OUT_W  = 16,
    parameter int FIFO_D = 4,
    localparam int CW    = CHAN > 1 ? $clog2(CHAN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CHAN-1:0]  adc_lvds_pin,
    output logic [CHAN-1:0]  adc_fb_pin,
    output logic [OUT_W-1:0] out_data,
    output logic [CW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int LFS = log_fs(BOSR, STGS);
    localparam int DCW = $clog2(BOSR);
    localparam int WMW = $clog2(STGS + 1);
    localparam int SHR = LFS >= OUT_W ? LFS - OUT_W : 0;
    localparam int SHL = LFS < OUT_W ? OUT_W - LFS : 0;

    if (!params_ok(CHAN, BOSR, STGS, WDTH, FIFO_D)) begin : g_bad_params
        $error("sigma_delta_adc_mc: illegal parameter combination");
    end

    logic [CHAN-1:0]     bit_q;
    logic [WDTH-1:0]     integ [CHAN][STGS];
    logic [WDTH-1:0]     snap  [CHAN];
    logic [WDTH-1:0]     dly   [CHAN][STGS];
    logic [WDTH-1:0]     d     [STGS];
    logic [WDTH-1:0]     res;
    logic [DCW-1:0]      dec_cnt;
    logic                strobe, warm_done, push, pop, full, empty;
    seq_t                state;
    logic [CW-1:0]       ch;
    logic [WMW-1:0]      warm;
    logic [LFS-1:0]      sat;
    logic [OUT_W-1:0]    scaled;
    logic [OUT_W+CW-1:0] head;

    assign adc_fb_pin = bit_q;
    assign strobe     = dec_cnt == DCW'(BOSR - 1);
    assign warm_done  = warm == WMW'(STGS);
    assign push       = state == COMB && warm_done;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign {out_chan, out_data} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q   <= '0;
            dec_cnt <= '0;
            for (int c = 0; c < CHAN; c++) begin
                snap[c] <= '0;
                for (int k = 0; k < STGS; k++) integ[c][k] <= '0;
            end
        end else begin
            bit_q   <= adc_lvds_pin;
            dec_cnt <= dec_cnt + 1'b1;
            for (int c = 0; c < CHAN; c++) begin
                integ[c][0] <= integ[c][0] + WDTH'(bit_q[c]);
                for (int k = 1; k < STGS; k++) integ[c][k] <= integ[c][k] + integ[c][k-1];
                if (strobe) snap[c] <= integ[c][STGS-1];
            end
        end
    end

    // d[k] is the input to comb stage k; it becomes that stage's delay value once the channel is sequenced
    always_comb begin
        logic [WDTH-1:0] t;
        t = snap[ch];
        for (int k = 0; k < STGS; k++) begin
            d[k] = t;
            t    = t - dly[ch][k];
        end
        res = t;
    end

    // a full-scale result of exactly 2^LFS is clamped so it cannot wrap to zero
    assign sat    = res[LFS] ? '1 : res[LFS-1:0];
    assign scaled = OUT_W'({{OUT_W{1'b0}}, sat} >> SHR << SHL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            warm  <= '0;
            for (int c = 0; c < CHAN; c++)
                for (int k = 0; k < STGS; k++) dly[c][k] <= '0;
        end else if (state == IDLE) begin
            if (strobe) begin
                state <= COMB;
                ch    <= '0;
            end
        end else begin
            for (int k = 0; k < STGS; k++) dly[ch][k] <= d[k];
            if (ch == CW'(CHAN - 1)) begin
                state <= IDLE;
                if (!warm_done) warm <= warm + 1'b1;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

    sd_sample_fifo #(.DW(OUT_W + CW), .DEPTH(FIFO_D)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  ({ch, scaled}),
        .full (full),
        .empty(empty),
        .head (head)
    );
endmodule

// File: tb/tb_sigma_delta_adc_mc.sv
// tb_sigma_delta_adc_mc: directed and random checks of sigma_delta_adc_mc against an impulse-response
// CIC model and a bounded FIFO queue model.
module tb_sigma_delta_adc_mc;
    localparam int CHAN = 2, R = 16, STGS = 2, OUT_W = 8, WDTH = 10, FD = 4;
    localparam int FS = 256;
    localparam int HL = STGS * (R - 1) + 1;

    typedef struct {int ch; int val;} ent_t;

    logic clk = 0, rst = 1;
    logic [CHAN-1:0] lvds = '0, fb;
    logic [OUT_W-1:0] out_data;
    logic [0:0] out_chan;
    logic out_valid, out_ready = 0, overflow;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int h[HL];
    bit movf;
    ent_t mq[$];
    logic [CHAN-1:0] hist[2048];

    sigma_delta_adc_mc #(.CHAN(CHAN), .BOSR(R), .STGS(STGS), .WDTH(WDTH), .OUT_W(OUT_W), .FIFO_D(FD)) dut (
        .clk(clk), .rst(rst), .adc_lvds_pin(lvds), .adc_fb_pin(fb), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // impulse response of STGS cascaded length-R boxcars
    task automatic build_h();
        int tmp[HL];
        int len = 1;
        h = '{default: 0};
        h[0] = 1;
        repeat (STGS) begin
            tmp = '{default: 0};
            for (int i = 0; i < len + R - 1; i++)
                for (int k = 0; k < R; k++)
                    if (i - k >= 0 && i - k < len) tmp[i] += h[i - k];
            h = tmp;
            len += R - 1;
        end
    endtask

    function automatic int b_at(int c, int s);
        return s <= 0 ? 0 : int'(hist[s - 1][c]);
    endfunction

    // frame n closes at state n*R-1; each integrator adds one cycle of delay
    function automatic int frame_val(int c, int n);
        int y = 0;
        int t = n * R - 1;
        for (int j = 0; j < HL; j++) y += h[j] * b_at(c, t - STGS - j);
        return y > FS - 1 ? FS - 1 : y;
    endfunction

    task automatic tick();
        bit do_pop;
        int s0, c, n;
        ent_t e;
        hist[cyc] = lvds;
        s0 = cyc;
        c = s0 % R;
        n = s0 / R;
        do_pop = mq.size() != 0 && out_ready;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (n > STGS && c < CHAN) begin
            e.ch = c;
            e.val = frame_val(c, n);
            if (mq.size() < FD) mq.push_back(e);
            else movf = 1;
        end
        cyc++;
        @(negedge clk);
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data", 32'(out_data), mq[0].val);
            chk("chan", 32'(out_chan), mq[0].ch);
        end
        chk("overflow", 32'(overflow), 32'(movf));
        chk("fb", 32'(fb), cyc > 0 ? 32'(hist[cyc - 1]) : 32'd0);
    endtask

    // mode 0: ch0=1 ch1=0; mode 1: ch0 toggles, ch1 1,0,0,0; mode 2: random pins and ready
    task automatic run_to(int s, int mode);
        while (cyc < s) begin
            if (mode == 0) lvds = 2'b01;
            else if (mode == 1) lvds = {1'(cyc % 4 == 0), 1'(cyc % 2 == 0)};
            else begin
                lvds = CHAN'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1;
        lvds = '0;
        repeat (2) @(negedge clk);
        mq.delete();
        movf = 0;
        cyc = 0;
        rst = 0;
    endtask

    initial begin
        build_h();

        do_reset();
        out_ready = 1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_chan", 32'(out_chan), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_fb", 32'(fb), 0);
        run_to(48, 0);
        chk("early_valid", 32'(out_valid), 0);
        run_to(49, 0);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_chan", 32'(out_chan), 0);
        run_to(81, 0);
        chk("const_ch0", 32'(out_data), 255);
        chk("const_ch0_id", 32'(out_chan), 0);
        run_to(82, 0);
        chk("const_ch1", 32'(out_data), 0);
        chk("const_ch1_id", 32'(out_chan), 1);

        do_reset();
        run_to(81, 1);
        chk("toggle_ch0", 32'(out_data), 128);
        run_to(82, 1);
        chk("pattern_ch1", 32'(out_data), 64);

        do_reset();
        run_to(200, 2);

        do_reset();
        out_ready = 0;
        run_to(80, 0);
        chk("bp_no_ovf", 32'(overflow), 0);
        chk("bp_full_valid", 32'(out_valid), 1);
        run_to(82, 0);
        chk("bp_ovf", 32'(overflow), 1);
        run_to(90, 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_chan", 32'(out_chan), i % 2);
            tick();
        end
        chk("drained", 32'(out_valid), 0);
        run_to(120, 0);
        chk("ovf_sticky", 32'(overflow), 1);

        do_reset();
        out_ready = 0;
        run_to(80, 0);
        out_ready = 1;
        run_to(82, 0);
        out_ready = 0;
        chk("pp_no_ovf", 32'(overflow), 0);
        run_to(84, 0);
        out_ready = 1;
        run_to(87, 0);
        chk("pp_level4", 32'(out_valid), 1);
        run_to(88, 0);
        chk("pp_empty", 32'(out_valid), 0);

        do_reset();
        out_ready = 1;
        run_to(49, 0);
        chk("pre_abort_valid", 32'(out_valid), 1);
        rst = 1;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_data", 32'(out_data), 0);
        chk("abort_chan", 32'(out_chan), 0);
        chk("abort_overflow", 32'(overflow), 0);
        chk("abort_fb", 32'(fb), 0);
        do_reset();
        run_to(48, 0);
        chk("rewarm_early", 32'(out_valid), 0);
        run_to(49, 0);
        chk("rewarm_valid", 32'(out_valid), 1);
        run_to(70, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
